// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised FIFO controller.
//   state_t  : 3-bit controller state encoding (INIT..RDWR); 3'b111 is unused
//              and never produced by the next-state decode.
//   REQ_*    : 2-bit request encodings of {wr_en, rd_en}.
// ---------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'b000,
        ST_NO_OP  = 3'b001,
        ST_WRITE  = 3'b010,
        ST_WR_ERR = 3'b011,
        ST_READ   = 3'b100,
        ST_RD_ERR = 3'b101,
        ST_RDWR   = 3'b110
    } state_t;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_RD   = 2'b01;
    localparam logic [1:0] REQ_WR   = 2'b10;
    localparam logic [1:0] REQ_RDWR = 2'b11;

endpackage

// File: rtl/fifo_reg_file.sv
// ---------------------------------------------------------------------------
// fifo_reg_file
// DEPTH x DATA_WIDTH storage array for the FIFO. Synchronous write, registered
// read. The array itself is never reset; only the read data register is.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (clears rdata only)
//   we       in   write enable
//   waddr    in   write address (ADDR_WIDTH)
//   wdata    in   write data (DATA_WIDTH)
//   re       in   read enable; rdata updates on the clock edge when set
//   raddr    in   read address (ADDR_WIDTH)
//   rdata    out  registered read data (DATA_WIDTH), holds when re=0
// ---------------------------------------------------------------------------
module fifo_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The controller never reads and writes the same entry on one edge:
    // that would need wr_ptr == rd_ptr with 0 < count < DEPTH, which cannot
    // happen, so no write-through bypass is required.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_ctrl_param.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_param
// Parametrised synchronous FIFO (controller plus storage) between the DMAC
// request side (writer) and the ALU operand side (reader).
//
// Optional feature macro: FIFO_SIMUL_RDWR_EN
//   undefined : wr_en & rd_en together is treated as NO_OP (nothing moves).
//   defined   : wr_en & rd_en together performs write and read in one cycle
//               (state RDWR); degrades to WRITE when empty, READ when full.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous reset, active low
//   wr_en       in   write request
//   rd_en       in   read request
//   din         in   write data (DATA_WIDTH)
//   dout        out  registered read data (DATA_WIDTH), valid with rd_ack
//   data_count  out  occupancy 0..DEPTH (ADDR_WIDTH+1)
//   full        out  data_count == DEPTH
//   empty       out  data_count == 0
//   wr_ack      out  state is WRITE or RDWR
//   wr_err      out  state is WR_ERR
//   rd_ack      out  state is READ or RDWR
//   rd_err      out  state is RD_ERR
//
// The ack/err flags are Moore outputs decoded from the state register, so
// they appear one cycle after the request edge, together with the updated
// dout and data_count.
// ---------------------------------------------------------------------------
module fifo_ctrl_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    // Occupancy value meaning "full": a single 1 in the MSB of the counter.
    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  cnt_full;
    logic                  cnt_empty;
    logic                  do_wr;
    logic                  do_rd;

    assign cnt_full  = (data_count == CNT_FULL);
    assign cnt_empty = (data_count == '0);
    assign full      = cnt_full;
    assign empty     = cnt_empty;

    // Next state depends only on the request and the pre-edge occupancy,
    // never on the current state, so the unused code 3'b111 (or any other
    // state) falls back into the normal decode on the next edge.
    always_comb begin
        next_state = ST_NO_OP;
        case ({wr_en, rd_en})
            REQ_NONE: next_state = ST_NO_OP;
            REQ_WR:   next_state = cnt_full  ? ST_WR_ERR : ST_WRITE;
            REQ_RD:   next_state = cnt_empty ? ST_RD_ERR : ST_READ;
            REQ_RDWR: begin
`ifdef FIFO_SIMUL_RDWR_EN
                // An empty FIFO has nothing to read and a full one has no
                // room, so the combined request degrades to the single
                // transfer that is legal.
                if (cnt_empty) begin
                    next_state = ST_WRITE;
                end else if (cnt_full) begin
                    next_state = ST_READ;
                end else begin
                    next_state = ST_RDWR;
                end
`else
                next_state = ST_NO_OP;
`endif
            end
            default:  next_state = state_t'(3'bxxx);
        endcase
    end

    // Transfers happen on the same edge that loads the new state.
    assign do_wr = (next_state == ST_WRITE) || (next_state == ST_RDWR);
    assign do_rd = (next_state == ST_READ)  || (next_state == ST_RDWR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
        end else begin
            state <= next_state;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous write and read leaves the occupancy unchanged.
            case ({do_wr, do_rd})
                2'b10:   data_count <= data_count + 1'b1;
                2'b01:   data_count <= data_count - 1'b1;
                default: data_count <= data_count;
            endcase
        end
    end

    fifo_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_reg_file (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (do_wr),
        .waddr   (wr_ptr),
        .wdata   (din),
        .re      (do_rd),
        .raddr   (rd_ptr),
        .rdata   (dout)
    );

    always_comb begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        case (state)
            ST_WRITE:  wr_ack = 1'b1;
            ST_WR_ERR: wr_err = 1'b1;
            ST_READ:   rd_ack = 1'b1;
            ST_RD_ERR: rd_err = 1'b1;
            ST_RDWR: begin
                wr_ack = 1'b1;
                rd_ack = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl_param
// Self-checking bench for fifo_ctrl_param (DATA_WIDTH=32, ADDR_WIDTH=4).
// Written data is pushed to a scoreboard queue when a write is driven and the
// FIFO model accepts it; it is popped and compared against dout when the model
// says a read took place. Build with +define+FIFO_SIMUL_RDWR_EN to exercise the
// simultaneous read/write mode.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [AW:0]   data_count;
    logic          full;
    logic          empty;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;

    fifo_ctrl_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .din        (din),
        .dout       (dout),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_bad = 0;
    string         phase = "init";

    logic [DW-1:0] sb_q[$];
    int            m_count = 0;
    logic [DW-1:0] m_dout  = '0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got=0x%0h expected=0x%0h", phase, tag, got, exp);
        end
    endtask

    // One request cycle: drive at the falling edge, let the model decide the
    // outcome, then check every output just after the rising edge.
    task automatic op(input logic w, input logic r, input logic [DW-1:0] d);
        logic e_wa, e_we, e_ra, e_re;
        logic do_w, do_r;
        e_wa = 1'b0; e_we = 1'b0; e_ra = 1'b0; e_re = 1'b0;
        do_w = 1'b0; do_r = 1'b0;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        if (w && !r) begin
            if (m_count < DEPTH) do_w = 1'b1; else e_we = 1'b1;
        end else if (r && !w) begin
            if (m_count > 0) do_r = 1'b1; else e_re = 1'b1;
        end else if (w && r) begin
`ifdef FIFO_SIMUL_RDWR_EN
            if (m_count == 0) begin
                do_w = 1'b1;
            end else if (m_count == DEPTH) begin
                do_r = 1'b1;
            end else begin
                do_w = 1'b1;
                do_r = 1'b1;
            end
`endif
        end
        e_wa = do_w;
        e_ra = do_r;
        if (do_w) sb_q.push_back(d);
        @(posedge clk);
        #1;
        if (do_r) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                m_dout = sb_q.pop_front();
            end
        end
        m_count = m_count + (do_w ? 1 : 0) - (do_r ? 1 : 0);
        chk("wr_ack", {31'd0, wr_ack}, {31'd0, e_wa});
        chk("wr_err", {31'd0, wr_err}, {31'd0, e_we});
        chk("rd_ack", {31'd0, rd_ack}, {31'd0, e_ra});
        chk("rd_err", {31'd0, rd_err}, {31'd0, e_re});
        chk("count",  {27'd0, data_count}, m_count);
        chk("full",   {31'd0, full},  (m_count == DEPTH) ? 32'd1 : 32'd0);
        chk("empty",  {31'd0, empty}, (m_count == 0)     ? 32'd1 : 32'd0);
        chk("dout",   dout, m_dout);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, '0);
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;

        // reset state
        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        chk("count", {27'd0, data_count}, 32'd0);
        chk("empty", {31'd0, empty}, 32'd1);
        chk("full",  {31'd0, full},  32'd0);
        chk("acks",  {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
        chk("dout",  dout, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        // asynchronous reset in the middle of a write burst
        phase = "reset_mid";
        op(1'b1, 1'b0, 32'hA1);
        op(1'b1, 1'b0, 32'hA2);
        op(1'b0, 1'b1, '0);
        op(1'b1, 1'b0, 32'hA3);
        @(negedge clk);
        wr_en = 1'b1;
        din   = 32'hA4;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("count",  {27'd0, data_count}, 32'd0);
        chk("empty",  {31'd0, empty}, 32'd1);
        chk("dout",   dout, 32'd0);
        chk("wr_ack", {31'd0, wr_ack}, 32'd0);
        sb_q.delete();
        m_count = 0;
        m_dout  = '0;
        @(negedge clk);
        wr_en   = 1'b0;
        reset_n = 1'b1;
        idle();

        // fill to full, then one write too many
        phase = "fill";
        for (int i = 1; i <= DEPTH; i++) op(1'b1, 1'b0, i);
        op(1'b1, 1'b0, 32'hDEAD);

        // drain in order, then one read too many (dout holds 0x10)
        phase = "drain";
        for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, '0);
        op(1'b0, 1'b1, '0);
        chk("dout_hold", dout, 32'h10);

        // pointer wrap with random data
        phase = "wrap";
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) op(1'b1, 1'b0, $urandom);
            for (int i = 0; i < 10; i++) op(1'b0, 1'b1, '0);
        end
        idle();

        // simultaneous request with 5 entries stored
        phase = "simul_mid";
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 32'h500 + i);
        op(1'b1, 1'b1, 32'h5AA);
        op(1'b1, 1'b1, 32'h5BB);
        while (m_count > 0) op(1'b0, 1'b1, '0);

        // simultaneous request when empty and when full
        phase = "simul_empty";
        op(1'b1, 1'b1, 32'h600);
        phase = "simul_full";
        while (m_count < DEPTH) op(1'b1, 1'b0, $urandom);
        op(1'b1, 1'b1, 32'h700);
        while (m_count > 0) op(1'b0, 1'b1, '0);
        idle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Safety net: the stimulus is a fixed number of cycles, so this only
    // fires if something stalls the initial block.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got=running expected=finished");
        $fatal(1);
    end

endmodule
